// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC sequencer and its next-PC selector.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

  localparam int          ADDR_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          JUMP_INDEX_W     = 26;
  localparam int          WORD_SHIFT       = 2;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux: JR, then J/JAL, then taken branch, then PC+4.
module next_pc_select
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0]       pc_plus4_i,
  input  logic                    branch_taken_i,
  input  logic [ADDR_W-1:0]       branch_offset_i,
  input  logic                    jump_i,
  input  logic [JUMP_INDEX_W-1:0] jump_index_i,
  input  logic                    jump_reg_i,
  input  logic [ADDR_W-1:0]       jump_reg_target_i,
  output logic [ADDR_W-1:0]       next_pc_o,
  output logic                    misaligned_o
);

  logic [ADDR_W-1:0] branchTarget;
  logic [ADDR_W-1:0] jumpTarget;

  // Both targets wrap modulo 2^32; the region bits come from PC+4, not PC.
  assign branchTarget = pc_plus4_i + (branch_offset_i << WORD_SHIFT);
  assign jumpTarget   = {pc_plus4_i[ADDR_W-1:ADDR_W-4], jump_index_i, 2'b00};
  assign misaligned_o = jump_reg_i && (jump_reg_target_i[1:0] != 2'b00);

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_reg_i) begin
      next_pc_o = jump_reg_target_i;
    end else if (jump_i) begin
      next_pc_o = jumpTarget;
    end else if (branch_taken_i) begin
      next_pc_o = branchTarget;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetch/execute handshake FSM, stall handling and halt/address-error capture.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ready,
  output logic                    instr_valid,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [ADDR_W-1:0]       branch_offset,
  input  logic                    jump,
  input  logic [JUMP_INDEX_W-1:0] jump_index,
  input  logic                    jump_reg,
  input  logic [ADDR_W-1:0]       jump_reg_target,
  input  logic                    halt,
  output logic [ADDR_W-1:0]       pc,
  output logic [ADDR_W-1:0]       pc_plus4,
  output logic                    halted,
  output logic                    addr_error
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              addrError_q, addrError_d;
  logic [ADDR_W-1:0] nextPc;
  logic              misaligned;
  logic              reqRaw;
  logic              validRaw;

  assign pc_plus4 = pc_q + PC_STEP;

  next_pc_select u_next_pc_select (
    .pc_plus4_i        (pc_plus4),
    .branch_taken_i    (branch_taken),
    .branch_offset_i   (branch_offset),
    .jump_i            (jump),
    .jump_index_i      (jump_index),
    .jump_reg_i        (jump_reg),
    .jump_reg_target_i (jump_reg_target),
    .next_pc_o         (nextPc),
    .misaligned_o      (misaligned)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addrError_d = addrError_q;
    reqRaw      = 1'b0;
    validRaw    = 1'b0;
    unique case (state_q)
      FETCH: begin
        reqRaw = 1'b1;
        if (imem_ready) state_d = EXEC;
      end
      EXEC: begin
        validRaw = 1'b1;
        // A stalled cycle must not observe redirects, so everything below is gated by !stall.
        if (!stall) begin
          if (misaligned) begin
            state_d     = HALTED;
            addrError_d = 1'b1;
          end else if (halt) begin
            state_d = HALTED;
          end else begin
            pc_d    = nextPc;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      addrError_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addrError_q <= addrError_d;
    end
  end

  // Handshake outputs are forced low for the whole time reset is held, not just after the edge.
  assign imem_req    = reqRaw & ~reset;
  assign instr_valid = validRaw & ~reset;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALTED);
  assign addr_error  = addrError_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance covers the RESET_PC wrap-around case.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset2 = 1'b1;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        jump_reg = 1'b0;
  logic [31:0] jump_reg_target = 32'h0;
  logic        halt = 1'b0;

  logic        imem_req, instr_valid, halted, addr_error;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic        imem_req2, instr_valid2, halted2, addr_error2;
  logic [31:0] imem_addr2, pc2, pc_plus42;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .instr_valid(instr_valid), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .jump_reg(jump_reg), .jump_reg_target(jump_reg_target),
    .halt(halt), .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .addr_error(addr_error)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(32)) dutWrap (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .instr_valid(instr_valid2), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .jump_reg(jump_reg), .jump_reg_target(jump_reg_target),
    .halt(halt), .pc(pc2), .pc_plus4(pc_plus42), .halted(halted2), .addr_error(addr_error2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearRedirects();
    branch_taken = 1'b0; branch_offset = 32'h0;
    jump = 1'b0; jump_index = 26'h0;
    jump_reg = 1'b0; jump_reg_target = 32'h0;
    halt = 1'b0;
  endtask

  // One fetch accepted immediately, then one unstalled EXEC cycle with the given redirects.
  task automatic applyStimulus(input logic jr, input logic [31:0] jrTarget,
                               input logic j, input logic [25:0] jIdx,
                               input logic br, input logic [31:0] brOff,
                               input logic hlt);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    jump_reg = jr; jump_reg_target = jrTarget;
    jump = j; jump_index = jIdx;
    branch_taken = br; branch_offset = brOff;
    halt = hlt;
    step();
    clearRedirects();
  endtask

  initial begin
    $display("[TB] start");
    step();
    checkOutput("reset_req_low", {31'b0, imem_req}, 32'h0);
    checkOutput("reset_valid_low", {31'b0, instr_valid}, 32'h0);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_halted", {31'b0, halted}, 32'h0);
    checkOutput("reset_addr_error", {31'b0, addr_error}, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("fetch_req", {31'b0, imem_req}, 32'h1);
    checkOutput("fetch_addr", imem_addr, 32'h0);

    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("wait_fetch_req", {31'b0, imem_req}, 32'h1);
      checkOutput("wait_fetch_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    checkOutput("exec_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("exec_req", {31'b0, imem_req}, 32'h0);
    checkOutput("exec_pc", pc, 32'h0);
    step();
    checkOutput("seq_pc4", pc, 32'h4);
    checkOutput("seq_valid_drop", {31'b0, instr_valid}, 32'h0);
    checkOutput("seq_req", {31'b0, imem_req}, 32'h1);
    checkOutput("seq_pc_plus4", pc_plus4, 32'h8);

    applyStimulus(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("seq_pc8", pc, 32'h8);

    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("jr_to_100", pc, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    checkOutput("branch_back", pc, 32'h0000_00FC);

    applyStimulus(1'b1, 32'h4000_0010, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("jr_to_4000_0010", pc, 32'h4000_0010);
    applyStimulus(1'b0, 32'h0, 1'b1, 26'h0000_040, 1'b1, 32'h0000_0010, 1'b0);
    checkOutput("jump_beats_branch", pc, 32'h4000_0100);

    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    stall = 1'b1; jump_reg = 1'b1; jump_reg_target = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("stall_pc_hold", pc, 32'h4000_0100);
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'h1);
    end
    stall = 1'b0;
    step();
    clearRedirects();
    checkOutput("stall_release_pc", pc, 32'h0000_0200);
    checkOutput("stall_release_req", {31'b0, imem_req}, 32'h1);

    applyStimulus(1'b1, 32'h0000_0202, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("misalign_halted", {31'b0, halted}, 32'h1);
    checkOutput("misalign_addr_error", {31'b0, addr_error}, 32'h1);
    checkOutput("misalign_pc", pc, 32'h0000_0200);
    imem_ready = 1'b1; jump = 1'b1; jump_index = 26'h123;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("halted_req", {31'b0, imem_req}, 32'h0);
      checkOutput("halted_valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("halted_pc", pc, 32'h0000_0200);
      checkOutput("halted_sticky", {31'b0, halted}, 32'h1);
    end
    clearRedirects();
    imem_ready = 1'b0;

    // Reset during FETCH with imem_ready high must not let EXEC through.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    imem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("midfetch_req_gated", {31'b0, imem_req}, 32'h0);
    step();
    reset = 1'b0;
    imem_ready = 1'b0;
    #1;
    checkOutput("midfetch_no_exec", {31'b0, instr_valid}, 32'h0);
    checkOutput("midfetch_refetch", {31'b0, imem_req}, 32'h1);
    checkOutput("midfetch_pc", pc, 32'h0);
    checkOutput("midfetch_err_clear", {31'b0, addr_error}, 32'h0);
    checkOutput("midfetch_halt_clear", {31'b0, halted}, 32'h0);

    applyStimulus(1'b0, 32'h0, 1'b1, 26'h0000_040, 1'b0, 32'h0, 1'b1);
    checkOutput("halt_req_halted", {31'b0, halted}, 32'h1);
    checkOutput("halt_req_pc", pc, 32'h0);
    checkOutput("halt_req_no_err", {31'b0, addr_error}, 32'h0);

    step();
    reset2 = 1'b0;
    #1;
    checkOutput("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus4", pc_plus42, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc", pc2, 32'h0000_0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
